pam_demap_pack: RTL and testbench

PAM_DEMAP_PACK -- requirements
Module: pam_demap_pack

---
 rtl/pam_rx_pkg.sv | 15 +
 rtl/pam_demap_pack_if.sv | 23 ++
 rtl/pam_slicer.sv | 10 +
 rtl/pam_demap_pack.sv | 85 ++++++++
 tb/tb_pam_demap_pack.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/pam_rx_pkg.sv
// pam_rx_pkg: shared PAM receiver sizing helpers, default geometry and FSM encoding.
package pam_rx_pkg;
    function automatic int bps_of(input int order);
        return $clog2(order);
    endfunction
    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    localparam int BPS = bps_of(4);
    localparam int SPW = 32 / BPS;
    localparam int WPF = 1024 / SPW;
    localparam int SYM_CNT_W = cnt_w(SPW);
    localparam int WORD_CNT_W = cnt_w(WPF);
    typedef enum logic [1:0] {IDLE = 2'd0, PACK = 2'd1, DRAIN = 2'd2} state_t;
endpackage

// File: rtl/pam_demap_pack_if.sv
// pam_demap_pack_if: sample input and AXI-Stream output bundle of the PAM demapper/packer.
interface pam_demap_pack_if #(
    parameter int AD_CVER_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic [AD_CVER_WIDTH-1:0] syn_demodu_data;
    logic syn_demodu_valid;
    logic syn_demodu_ready;
    logic [DATA_WIDTH-1:0] S_AXIS_tdata;
    logic [DATA_WIDTH/8-1:0] S_AXIS_tkeep;
    logic S_AXIS_tlast;
    logic S_AXIS_tvalid;
    logic S_AXIS_tready;
    logic frame_done;
    modport master (
        input syn_demodu_data, syn_demodu_valid, S_AXIS_tready,
        output syn_demodu_ready, S_AXIS_tdata, S_AXIS_tkeep, S_AXIS_tlast, S_AXIS_tvalid, frame_done
    );
    modport slave (
        output syn_demodu_data, syn_demodu_valid, S_AXIS_tready,
        input syn_demodu_ready, S_AXIS_tdata, S_AXIS_tkeep, S_AXIS_tlast, S_AXIS_tvalid, frame_done
    );
endinterface

// File: rtl/pam_slicer.sv
// pam_slicer: uniform-threshold PAM decision, the top BPS bits of an offset-binary sample.
module pam_slicer #(
    parameter int AD_CVER_WIDTH = 12,
    parameter int BPS = 2
) (
    input  logic [AD_CVER_WIDTH-1:0] sample,
    output logic [BPS-1:0] symbol
);
    assign symbol = sample[AD_CVER_WIDTH-1 -: BPS];
endmodule

// File: rtl/pam_demap_pack.sv
// pam_demap_pack: slices PAM samples into symbols, packs them LSB-first into words
// and streams framed words over AXI-Stream with tlast and a frame_done pulse.
module pam_demap_pack
    import pam_rx_pkg::*;
#(
    parameter int AD_CVER_WIDTH = 12,
    parameter int PAM_ORDER = 4,
    parameter int DATA_WIDTH = 32,
    parameter int LENGTH_DATA = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic [AD_CVER_WIDTH-1:0] syn_demodu_data,
    input  logic syn_demodu_valid,
    output logic syn_demodu_ready,
    output logic [DATA_WIDTH-1:0] S_AXIS_tdata,
    output logic [DATA_WIDTH/8-1:0] S_AXIS_tkeep,
    output logic S_AXIS_tlast,
    output logic S_AXIS_tvalid,
    input  logic S_AXIS_tready,
    output logic frame_done
);
    localparam int NB = bps_of(PAM_ORDER);
    localparam int NS = DATA_WIDTH / NB;
    localparam int NW = LENGTH_DATA / NS;
    localparam int SW = cnt_w(NS);
    localparam int WW = cnt_w(NW);
    state_t state;
    logic [SW-1:0] sym_cnt;
    logic [WW-1:0] word_cnt;
    logic [NB-1:0] sym;
    logic [DATA_WIDTH-1:0] acc, nxt;
    logic accept, done, last_word, xfer;
    pam_slicer #(.AD_CVER_WIDTH(AD_CVER_WIDTH), .BPS(NB)) u_slicer (
        .sample(syn_demodu_data),
        .symbol(sym)
    );
    assign S_AXIS_tkeep = '1;
    assign xfer = S_AXIS_tvalid && S_AXIS_tready;
    // Only the word-completing symbol needs a free output register, so stall just there.
    assign syn_demodu_ready = !rst && state != DRAIN
        && !(S_AXIS_tvalid && !S_AXIS_tready && sym_cnt == SW'(NS - 1));
    assign accept = syn_demodu_valid && syn_demodu_ready;
    assign done = accept && sym_cnt == SW'(NS - 1);
    assign last_word = word_cnt == WW'(NW - 1);
    always_comb begin
        nxt = acc;
        nxt[int'(sym_cnt) * NB +: NB] = sym;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sym_cnt <= '0;
            word_cnt <= '0;
            acc <= '0;
            S_AXIS_tdata <= '0;
            S_AXIS_tlast <= 1'b0;
            S_AXIS_tvalid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= xfer && S_AXIS_tlast;
            if (xfer) begin
                S_AXIS_tvalid <= 1'b0;
                S_AXIS_tlast <= 1'b0;
            end
            if (accept) begin
                acc <= nxt;
                sym_cnt <= done ? '0 : sym_cnt + 1'b1;
            end
            // A completion overrides the transfer clear, so back-to-back words keep tvalid high.
            if (done) begin
                S_AXIS_tdata <= nxt;
                S_AXIS_tvalid <= 1'b1;
                S_AXIS_tlast <= last_word;
                word_cnt <= last_word ? '0 : word_cnt + 1'b1;
            end
            case (state)
                IDLE: state <= done && last_word ? DRAIN : accept ? PACK : IDLE;
                PACK: state <= done && last_word ? DRAIN : PACK;
                DRAIN: state <= xfer && S_AXIS_tlast ? IDLE : DRAIN;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pam_demap_pack.sv
// tb_pam_demap_pack: directed checks of slicing, packing, framing, backpressure,
// reset abort and frame gap for pam_demap_pack with default parameters.
module tb_pam_demap_pack;
    import pam_rx_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    pam_demap_pack_if bus ();
    pam_demap_pack dut (
        .clk(clk),
        .rst(rst),
        .syn_demodu_data(bus.syn_demodu_data),
        .syn_demodu_valid(bus.syn_demodu_valid),
        .syn_demodu_ready(bus.syn_demodu_ready),
        .S_AXIS_tdata(bus.S_AXIS_tdata),
        .S_AXIS_tkeep(bus.S_AXIS_tkeep),
        .S_AXIS_tlast(bus.S_AXIS_tlast),
        .S_AXIS_tvalid(bus.S_AXIS_tvalid),
        .S_AXIS_tready(bus.S_AXIS_tready),
        .frame_done(bus.frame_done)
    );
    logic [11:0] sl_in;
    logic [1:0] sl_out;
    pam_slicer #(.AD_CVER_WIDTH(12), .BPS(2)) u_sl (.sample(sl_in), .symbol(sl_out));
    int errors = 0;
    int checks = 0;
    logic [31:0] rx_q[$];
    int last_idx[$];
    int fd_cnt = 0;
    int fd0 = 0;
    int n_acc = 0;
    int stalls = 0;
    int drop_mod, changes, gap_bad;
    logic have;
    logic [31:0] held;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    always @(negedge clk) begin
        if (bus.S_AXIS_tvalid && bus.S_AXIS_tready) begin
            if (bus.S_AXIS_tlast) last_idx.push_back(rx_q.size());
            rx_q.push_back(bus.S_AXIS_tdata);
        end
        if (bus.frame_done) fd_cnt++;
    end
    function automatic logic [1:0] sym_of(input int seed, input int i);
        return 2'((i * 5 + i / 7 + seed) & 3);
    endfunction
    function automatic logic [11:0] smp_of(input int seed, input int i);
        return {sym_of(seed, i), 10'((i * 37) ^ seed)};
    endfunction
    function automatic logic [31:0] word_of(input int seed, input int w);
        logic [31:0] r = '0;
        for (int n = 0; n < SPW; n++) r[n*BPS +: BPS] = sym_of(seed, w * SPW + n);
        return r;
    endfunction
    function automatic int bad_words(input int seed, input int nw);
        int b = 0;
        for (int w = 0; w < nw && w < rx_q.size(); w++) if (rx_q[w] !== word_of(seed, w)) b++;
        return b;
    endfunction
    task automatic send(input logic [11:0] d);
        logic ok = 1'b0;
        bus.syn_demodu_data = d;
        bus.syn_demodu_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            ok = bus.syn_demodu_ready;
            if (!ok) stalls++;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (ok) n_acc++;
        else check("send_timeout", 64'(ok), 64'd1);
    endtask
    task automatic idle(input int n);
        bus.syn_demodu_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.syn_demodu_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rx_q.delete();
        last_idx.delete();
        fd0 = fd_cnt;
        n_acc = 0;
        stalls = 0;
    endtask
    task automatic check_frames(input string tag, input int seed, input int nw, input int nf);
        check({tag, "_count"}, 64'(rx_q.size()), 64'(nw));
        check({tag, "_data"}, 64'(bad_words(seed, nw)), 64'd0);
        check({tag, "_nlast"}, 64'(last_idx.size()), 64'(nf));
        check({tag, "_last0"}, 64'(last_idx.size() > 0 ? last_idx[0] : -1), 64'(WPF - 1));
        check({tag, "_fdone"}, 64'(fd_cnt - fd0), 64'(nf));
    endtask
    logic [11:0] sl_vec[5] = '{12'h000, 12'h3FF, 12'h400, 12'h800, 12'hFFF};
    logic [1:0] sl_exp[5] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [11:0] pat[4] = '{12'h000, 12'h400, 12'h800, 12'hC00};
    initial begin
        bus.S_AXIS_tready = 1'b1;
        bus.syn_demodu_valid = 1'b0;
        bus.syn_demodu_data = '0;
        sl_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(bus.syn_demodu_ready), 64'd0);
        check("rst_tvalid", 64'(bus.S_AXIS_tvalid), 64'd0);
        check("rst_tdata", 64'(bus.S_AXIS_tdata), 64'd0);
        check("rst_tlast", 64'(bus.S_AXIS_tlast), 64'd0);
        check("rst_fdone", 64'(bus.frame_done), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(bus.syn_demodu_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            sl_in = sl_vec[i];
            #1;
            check("slice", 64'(sl_out), 64'(sl_exp[i]));
        end
        @(posedge clk);
        #1;
        rx_q.delete();
        for (int i = 0; i < 16; i++) begin
            send(pat[i % 4]);
            if (i == 14) check("pack_tvalid_early", 64'(bus.S_AXIS_tvalid), 64'd0);
        end
        bus.syn_demodu_valid = 1'b0;
        @(negedge clk);
        check("pack_tvalid", 64'(bus.S_AXIS_tvalid), 64'd1);
        check("pack_tdata", 64'(bus.S_AXIS_tdata), 64'hE4E4E4E4);
        check("pack_tlast", 64'(bus.S_AXIS_tlast), 64'd0);
        check("pack_tkeep", 64'(bus.S_AXIS_tkeep), 64'hF);
        idle(2);
        check("pack_count", 64'(rx_q.size()), 64'd1);
        check("pack_word", 64'(rx_q.size() > 0 ? rx_q[0] : 32'h0), 64'hE4E4E4E4);
        // Continuous frame of top-level samples.
        reset_dut();
        for (int i = 0; i < 1024; i++) send(12'hC00);
        bus.syn_demodu_valid = 1'b0;
        @(negedge clk);
        check("drain_ready", 64'(bus.syn_demodu_ready), 64'd0);
        check("drain_tlast", 64'(bus.S_AXIS_tlast), 64'd1);
        idle(4);
        check("frame_stalls", 64'(stalls), 64'd0);
        check("frame_count", 64'(rx_q.size()), 64'd64);
        check("frame_nlast", 64'(last_idx.size()), 64'd1);
        check("frame_last0", 64'(last_idx.size() > 0 ? last_idx[0] : -1), 64'd63);
        check("frame_fdone", 64'(fd_cnt - fd0), 64'd1);
        begin
            int b = 0;
            foreach (rx_q[w]) if (rx_q[w] !== 32'hFFFFFFFF) b++;
            check("frame_data", 64'(b), 64'd0);
        end
        check("idle_ready", 64'(bus.syn_demodu_ready), 64'd1);
        // Backpressure mid-frame.
        reset_dut();
        drop_mod = -1;
        changes = 0;
        have = 1'b0;
        held = '0;
        fork
            for (int i = 0; i < 1024; i++) send(smp_of(3, i));
            begin
                for (int c = 0; c < 5000 && n_acc < 190; c++) begin
                    @(posedge clk);
                    #2;
                end
                bus.S_AXIS_tready = 1'b0;
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (!bus.syn_demodu_ready && drop_mod < 0) drop_mod = n_acc % 16;
                    if (bus.S_AXIS_tvalid) begin
                        if (!have) begin
                            have = 1'b1;
                            held = bus.S_AXIS_tdata;
                        end else if (bus.S_AXIS_tdata !== held) changes++;
                    end
                end
                @(posedge clk);
                #2;
                bus.S_AXIS_tready = 1'b1;
            end
        join
        idle(4);
        check("bp_drop_sym", 64'(drop_mod), 64'd15);
        check("bp_held", 64'(have), 64'd1);
        check("bp_stable", 64'(changes), 64'd0);
        check_frames("bp", 3, 64, 1);
        // Reset aborts a frame after 700 samples.
        reset_dut();
        for (int i = 0; i < 700; i++) send(smp_of(5, i));
        reset_dut();
        for (int i = 0; i < 1024; i++) send(smp_of(9, i));
        idle(4);
        check_frames("rst", 9, 64, 1);
        // Second frame offered while the first drains under backpressure.
        reset_dut();
        gap_bad = 0;
        fork
            for (int i = 0; i < 2048; i++) send(smp_of(11, i));
            begin
                for (int c = 0; c < 20000 && n_acc < 1020; c++) begin
                    @(posedge clk);
                    #2;
                end
                bus.S_AXIS_tready = 1'b0;
                for (int c = 0; c < 30; c++) begin
                    @(negedge clk);
                    if (n_acc >= 1024 && bus.syn_demodu_ready) gap_bad++;
                end
                check("gap_ready", 64'(bus.syn_demodu_ready), 64'd0);
                check("gap_hold", 64'(n_acc), 64'd1024);
                check("gap_tlast", 64'(bus.S_AXIS_tvalid && bus.S_AXIS_tlast), 64'd1);
                @(posedge clk);
                #2;
                bus.S_AXIS_tready = 1'b1;
            end
        join
        idle(4);
        check("gap_ready_cycles", 64'(gap_bad), 64'd0);
        check_frames("gap", 11, 128, 2);
        check("gap_last1", 64'(last_idx.size() > 1 ? last_idx[1] : -1), 64'd127);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
